// File: rtl/cond_pkg.sv
// Shared definitions for the condition unit: condition-code values, PSR bit
// positions and the output-buffer state encoding.
package cond_pkg;

  // Condition codes carried by Bcond/Jcond/Scond instructions
  localparam logic [3:0] CondEq = 4'd0;   // Z
  localparam logic [3:0] CondNe = 4'd1;   // !Z
  localparam logic [3:0] CondCs = 4'd2;   // C
  localparam logic [3:0] CondCc = 4'd3;   // !C
  localparam logic [3:0] CondHi = 4'd4;   // L
  localparam logic [3:0] CondLs = 4'd5;   // !L
  localparam logic [3:0] CondGt = 4'd6;   // N
  localparam logic [3:0] CondLe = 4'd7;   // !N
  localparam logic [3:0] CondFs = 4'd8;   // F
  localparam logic [3:0] CondFc = 4'd9;   // !F
  localparam logic [3:0] CondLo = 4'd10;  // !L & !Z
  localparam logic [3:0] CondHs = 4'd11;  // L | Z
  localparam logic [3:0] CondLt = 4'd12;  // !N & !Z
  localparam logic [3:0] CondGe = 4'd13;  // N | Z
  localparam logic [3:0] CondUc = 4'd14;  // always
  localparam logic [3:0] CondNv = 4'd15;  // never

  // PSR bit positions
  localparam int unsigned PsrC = 0;
  localparam int unsigned PsrF = 1;
  localparam int unsigned PsrL = 2;
  localparam int unsigned PsrZ = 3;
  localparam int unsigned PsrN = 4;

  // Output buffer: one result slot
  typedef enum logic {
    StEmpty = 1'b0,
    StFull  = 1'b1
  } cond_state_e;

endpackage

// File: rtl/cond_eval.sv
// Purely combinational condition-code decoder: maps a PSR value and a
// 4-bit condition code onto the taken/not-taken outcome.
module cond_eval #(
  parameter int unsigned PSR_W = 5
) (
  input  logic [PSR_W-1:0] psr,
  input  logic [3:0]       cond_code,
  output logic             taken
);
  import cond_pkg::*;

  logic w_c, w_f, w_l, w_z, w_n;

  assign w_c = psr[PsrC];
  assign w_f = psr[PsrF];
  assign w_l = psr[PsrL];
  assign w_z = psr[PsrZ];
  assign w_n = psr[PsrN];

  // Decode the condition code against the flag bits
  always_comb begin
    taken = 1'b0;
    case (cond_code)
      CondEq: taken = w_z;
      CondNe: taken = ~w_z;
      CondCs: taken = w_c;
      CondCc: taken = ~w_c;
      CondHi: taken = w_l;
      CondLs: taken = ~w_l;
      CondGt: taken = w_n;
      CondLe: taken = ~w_n;
      CondFs: taken = w_f;
      CondFc: taken = ~w_f;
      CondLo: taken = ~w_l & ~w_z;
      CondHs: taken = w_l | w_z;
      CondLt: taken = ~w_n & ~w_z;
      CondGe: taken = w_n | w_z;
      CondUc: taken = 1'b1;
      CondNv: taken = 1'b0;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// Condition unit: holds the processor status register, evaluates branch
// conditions against the forwarded PSR and buffers one result behind a
// valid/ready handshake.
// Optional statistics counters are built only when COND_STATS_EN is defined;
// otherwise eval_count/taken_count are tied to zero.
module cond_unit #(
  parameter int unsigned PSR_W = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PSR_W-1:0] flag_in,
  input  logic [PSR_W-1:0] flag_we,
  input  logic             flag_valid,
  input  logic             cond_req,
  input  logic [3:0]       cond_code,
  output logic             cond_ready,
  output logic             cond_valid,
  output logic             cond_taken,
  input  logic             cond_ack,
  output logic [PSR_W-1:0] psr,
  output logic [CNT_W-1:0] eval_count,
  output logic [CNT_W-1:0] taken_count
);
  import cond_pkg::*;

  logic [PSR_W-1:0] r_psr;
  logic [PSR_W-1:0] w_psr_fwd;
  cond_state_e      r_state;
  logic             r_taken;
  logic             w_taken;
  logic             w_accept;

  // Value the PSR takes at the coming edge; evaluation sees same-cycle writes
  assign w_psr_fwd = flag_valid ? ((r_psr & ~flag_we) | (flag_in & flag_we)) : r_psr;

  assign cond_ready = (r_state == StEmpty) | cond_ack;
  assign cond_valid = (r_state == StFull);
  assign cond_taken = r_taken;
  assign psr        = r_psr;
  assign w_accept   = cond_req & cond_ready;

  cond_eval #(
    .PSR_W (PSR_W)
  ) u_cond_eval (
    .psr       (w_psr_fwd),
    .cond_code (cond_code),
    .taken     (w_taken)
  );

  // PSR register with per-bit write enables
  always_ff @(posedge clk) begin
    if (reset) begin
      r_psr <= '0;
    end else begin
      r_psr <= w_psr_fwd;
    end
  end

  // Single-slot output buffer; result is held until the consumer acks
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StEmpty;
      r_taken <= 1'b0;
    end else begin
      case (r_state)
        StEmpty: begin
          if (w_accept) begin
            r_state <= StFull;
            r_taken <= w_taken;
          end
        end
        StFull: begin
          if (cond_ack) begin
            if (w_accept) begin
              r_taken <= w_taken;
            end else begin
              r_state <= StEmpty;
            end
          end
        end
        default: r_state <= StEmpty;
      endcase
    end
  end

`ifdef COND_STATS_EN
  logic [CNT_W-1:0] r_eval_cnt;
  logic [CNT_W-1:0] r_taken_cnt;

  // Saturating counts of accepted and taken evaluations
  always_ff @(posedge clk) begin
    if (reset) begin
      r_eval_cnt  <= '0;
      r_taken_cnt <= '0;
    end else if (w_accept) begin
      if (r_eval_cnt != '1) begin
        r_eval_cnt <= r_eval_cnt + 1'b1;
      end
      if (w_taken && (r_taken_cnt != '1)) begin
        r_taken_cnt <= r_taken_cnt + 1'b1;
      end
    end
  end

  assign eval_count  = r_eval_cnt;
  assign taken_count = r_taken_cnt;
`else
  assign eval_count  = '0;
  assign taken_count = '0;
`endif

endmodule

// File: tb/tb_cond_unit.sv
// Self-checking bench for cond_unit. Stimulus pushes expected results into a
// queue; a monitor pops and compares each result as the consumer takes it.
module tb_cond_unit;

  localparam int PSR_W = 5;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [PSR_W-1:0] flag_in = '0;
  logic [PSR_W-1:0] flag_we = '0;
  logic             flag_valid = 1'b0;
  logic             cond_req = 1'b0;
  logic [3:0]       cond_code = '0;
  logic             cond_ready;
  logic             cond_valid;
  logic             cond_taken;
  logic             cond_ack = 1'b0;
  logic [PSR_W-1:0] psr;
  logic [CNT_W-1:0] eval_count;
  logic [CNT_W-1:0] taken_count;

  cond_unit #(
    .PSR_W (PSR_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .flag_in     (flag_in),
    .flag_we     (flag_we),
    .flag_valid  (flag_valid),
    .cond_req    (cond_req),
    .cond_code   (cond_code),
    .cond_ready  (cond_ready),
    .cond_valid  (cond_valid),
    .cond_taken  (cond_taken),
    .cond_ack    (cond_ack),
    .psr         (psr),
    .eval_count  (eval_count),
    .taken_count (taken_count)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  bit   exp_q[$];
  logic [4:0] m_psr = '0;
  bit   m_full = 1'b0;
  int   m_eval = 0;
  int   m_taken = 0;

  // Reference condition table
  function automatic bit ref_cond(input logic [3:0] code, input logic [4:0] p);
    bit c, f, l, z, n;
    c = p[0]; f = p[1]; l = p[2]; z = p[3]; n = p[4];
    case (code)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return l;
      4'd5:  return !l;
      4'd6:  return n;
      4'd7:  return !n;
      4'd8:  return f;
      4'd9:  return !f;
      4'd10: return !l && !z;
      4'd11: return l || z;
      4'd12: return !n && !z;
      4'd13: return n || z;
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int exp_cnt(input int v);
`ifdef COND_STATS_EN
    return v;
`else
    return 0;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare each result at the point the consumer takes it
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && cond_valid && cond_ack) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL result: got unexpected result %0b expected none", cond_taken);
        end else begin
          check("result", {31'b0, cond_taken}, {31'b0, exp_q.pop_front()});
        end
      end
    end
  end

  // One clock of stimulus; checks visible state, then advances the model
  task automatic cycle(input bit fv, input logic [4:0] fwe, input logic [4:0] fin,
                       input bit req, input logic [3:0] code, input bit ack);
    logic [4:0] nxt;
    bit         rdy;
    @(posedge clk);
    #1;
    flag_valid = fv; flag_we = fwe; flag_in = fin;
    cond_req = req; cond_code = code; cond_ack = ack;
    #1;
    rdy = !m_full || ack;
    check("psr", {27'b0, psr}, {27'b0, m_psr});
    check("valid", {31'b0, cond_valid}, {31'b0, m_full});
    check("ready", {31'b0, cond_ready}, {31'b0, rdy});
    check("eval_count", {16'b0, eval_count}, exp_cnt(m_eval));
    check("taken_count", {16'b0, taken_count}, exp_cnt(m_taken));
    if (m_full && exp_q.size() > 0) check("held", {31'b0, cond_taken}, {31'b0, exp_q[0]});
    nxt = fv ? ((m_psr & ~fwe) | (fin & fwe)) : m_psr;
    if (req && rdy) begin
      exp_q.push_back(ref_cond(code, nxt));
      if (m_eval < 65535) m_eval++;
      if (ref_cond(code, nxt) && m_taken < 65535) m_taken++;
      m_full = 1'b1;
    end else if (ack && m_full) begin
      m_full = 1'b0;
    end
    m_psr = nxt;
  endtask

  // One reset cycle with live flag writes and a request that must be dropped
  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    flag_valid = 1'b1; flag_we = '1; flag_in = '1;
    cond_req = 1'b1; cond_code = 4'd14; cond_ack = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    flag_valid = 1'b0; cond_req = 1'b0;
    exp_q.delete();
    m_psr = '0; m_full = 1'b0; m_eval = 0; m_taken = 0;
    #1;
    check("rst_psr", {27'b0, psr}, 32'd0);
    check("rst_valid", {31'b0, cond_valid}, 32'd0);
    check("rst_taken", {31'b0, cond_taken}, 32'd0);
    check("rst_eval", {16'b0, eval_count}, 32'd0);
    check("rst_taken_cnt", {16'b0, taken_count}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Write Z then test EQ: psr=01000, result 1 one cycle after accept
    cycle(1'b1, 5'b01000, 5'b01000, 1'b0, 4'd0, 1'b0);
    cycle(1'b0, 5'b0, 5'b0, 1'b1, 4'd0, 1'b0);
    cycle(1'b0, 5'b0, 5'b0, 1'b0, 4'd0, 1'b0);
    check("req031_psr", {27'b0, psr}, 32'b01000);
    check("req031_valid", {31'b0, cond_valid}, 32'd1);
    check("req031_taken", {31'b0, cond_taken}, 32'd1);
    cycle(1'b0, 5'b0, 5'b0, 1'b0, 4'd0, 1'b1);
    cycle(1'b0, 5'b0, 5'b0, 1'b0, 4'd0, 1'b1);  // ack while empty is ignored

    // Same-cycle Z write is forwarded into NE
    do_reset();
    cycle(1'b1, 5'b01000, 5'b01000, 1'b1, 4'd1, 1'b1);
    cycle(1'b0, 5'b0, 5'b0, 1'b0, 4'd0, 1'b0);
    check("fwd_ne", {31'b0, cond_taken}, 32'd0);
    cycle(1'b0, 5'b0, 5'b0, 1'b0, 4'd0, 1'b1);

    // Full sweep, back to back, psr written in the evaluating cycle
    for (int p = 0; p < 32; p++) begin
      for (int c = 0; c < 16; c++) begin
        cycle(1'b1, 5'h1f, p[4:0], 1'b1, c[3:0], 1'b1);
      end
    end
    cycle(1'b0, 5'b0, 5'b0, 1'b0, 4'd0, 1'b1);

    // Stall: result held while psr changes and requests are refused
    do_reset();
    cycle(1'b1, 5'b00100, 5'b00100, 1'b1, 4'd4, 1'b0);
    cycle(1'b1, 5'h1f, 5'h00, 1'b1, 4'd4, 1'b0);
    cycle(1'b1, 5'h1f, 5'h1b, 1'b1, 4'd4, 1'b0);
    cycle(1'b1, 5'h1f, 5'b00100, 1'b1, 4'd4, 1'b0);
    check("stall_taken", {31'b0, cond_taken}, 32'd1);
    cycle(1'b0, 5'b0, 5'b0, 1'b1, 4'd5, 1'b1);
    cycle(1'b0, 5'b0, 5'b0, 1'b0, 4'd0, 1'b0);
    check("stall_new", {31'b0, cond_taken}, 32'd0);
    check("stall_valid", {31'b0, cond_valid}, 32'd1);
    cycle(1'b0, 5'b0, 5'b0, 1'b0, 4'd0, 1'b1);

    // Ten back-to-back always-true requests
    do_reset();
    for (int i = 0; i < 10; i++) cycle(1'b0, 5'b0, 5'b0, 1'b1, 4'd14, 1'b1);
    cycle(1'b0, 5'b0, 5'b0, 1'b0, 4'd0, 1'b1);
    cycle(1'b0, 5'b0, 5'b0, 1'b0, 4'd0, 1'b0);
    check("burst_eval", {16'b0, eval_count}, exp_cnt(10));
    check("burst_taken", {16'b0, taken_count}, exp_cnt(10));

    // Reset while a result is pending drops it
    cycle(1'b1, 5'h1f, 5'h1f, 1'b1, 4'd14, 1'b0);
    cycle(1'b0, 5'b0, 5'b0, 1'b0, 4'd0, 1'b0);
    check("pre_rst_valid", {31'b0, cond_valid}, 32'd1);
    do_reset();
    cycle(1'b0, 5'b0, 5'b0, 1'b0, 4'd0, 1'b1);
    cycle(1'b0, 5'b0, 5'b0, 1'b0, 4'd0, 1'b0);
    check("drain", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
